// File: rtl/tcu_pulse_meter.sv
// Pulse meter for a timing-control unit: measures the delay from a ref_clk rising
// edge to the next pulse_in rising edge, and the width of that pulse, in clk_in cycles.
// Optional macro TCU_PULSE_METER_SYNC_EN adds 2-flop input synchronizers.
module tcu_pulse_meter #(
    parameter int CNT_W = 6
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             ref_clk,
    input  logic             pulse_in,
    input  logic             arm,
    input  logic             ack,
    output logic [CNT_W-1:0] meas_delay,
    output logic [CNT_W-1:0] meas_width,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_REF  = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic             ref_s;
    logic             pulse_s;
    logic             ref_q;
    logic             pulse_q;
    logic             primed;
    logic             ref_rise;
    logic             pulse_rise;
    logic             pulse_fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_sat;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
`ifdef TCU_PULSE_METER_SYNC_EN
    logic [1:0] ref_sync;
    logic [1:0] pulse_sync;

    // Both inputs see identical latency, so delay and width are unaffected.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            ref_sync   <= 2'b00;
            pulse_sync <= 2'b00;
        end else begin
            ref_sync   <= {ref_sync[0], ref_clk};
            pulse_sync <= {pulse_sync[0], pulse_in};
        end
    end

    assign ref_s   = ref_sync[1];
    assign pulse_s = pulse_sync[1];
`else
    assign ref_s   = ref_clk;
    assign pulse_s = pulse_in;
`endif

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    // History flops track the input every cycle, but edges are masked until
    // the first post-reset cycle has loaded real history (no false edge at release).
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            ref_q   <= 1'b0;
            pulse_q <= 1'b0;
            primed  <= 1'b0;
        end else begin
            ref_q   <= ref_s;
            pulse_q <= pulse_s;
            primed  <= 1'b1;
        end
    end

    assign ref_rise   = primed &  ref_s   & ~ref_q;
    assign pulse_rise = primed &  pulse_s & ~pulse_q;
    assign pulse_fall = primed & ~pulse_s &  pulse_q;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign cnt_sat = (cnt == CNT_MAX);
    assign cnt_inc = cnt_sat ? cnt : cnt + CNT_ONE;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (arm) state_next = WAIT_REF;
            end
            WAIT_REF: begin
                if (ref_rise) state_next = pulse_rise ? WAIT_FALL : WAIT_RISE;
            end
            WAIT_RISE: begin
                if (pulse_rise) state_next = WAIT_FALL;
            end
            WAIT_FALL: begin
                if (pulse_fall) state_next = DONE;
            end
            DONE: begin
                if (ack) state_next = arm ? WAIT_REF : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        valid = 1'b0;
        busy  = 1'b0;
        unique case (state)
            WAIT_REF, WAIT_RISE, WAIT_FALL: busy  = 1'b1;
            DONE:                           valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Measurement datapath
    // ------------------------------------------------------------------
    // Results are written only on the completing transitions, so they hold
    // steady through DONE until the next measurement overwrites them.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            meas_delay <= '0;
            meas_width <= '0;
            overflow   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arm) begin
                        cnt      <= '0;
                        overflow <= 1'b0;
                    end
                end
                WAIT_REF: begin
                    if (ref_rise) begin
                        if (pulse_rise) begin
                            meas_delay <= '0;
                            cnt        <= CNT_ONE;
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                WAIT_RISE: begin
                    // The rise cycle itself counts toward the delay.
                    if (pulse_rise) begin
                        meas_delay <= cnt_inc;
                        cnt        <= CNT_ONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                    if (cnt_sat) overflow <= 1'b1;
                end
                WAIT_FALL: begin
                    if (pulse_fall) begin
                        meas_width <= cnt;
                    end else if (pulse_s) begin
                        cnt <= cnt_inc;
                        if (cnt_sat) overflow <= 1'b1;
                    end
                end
                DONE: begin
                    if (ack && arm) begin
                        cnt      <= '0;
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tcu_pulse_meter.sv
// Directed self-checking bench for tcu_pulse_meter (default CNT_W=6).
// Inputs change on the falling edge; outputs are sampled there too.
module tb_tcu_pulse_meter;

    logic       clk_in   = 1'b0;
    logic       reset    = 1'b0;
    logic       ref_clk  = 1'b0;
    logic       pulse_in = 1'b0;
    logic       arm      = 1'b0;
    logic       ack      = 1'b0;
    logic [5:0] meas_delay;
    logic [5:0] meas_width;
    logic       valid;
    logic       overflow;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    tcu_pulse_meter #(.CNT_W(6)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .ref_clk    (ref_clk),
        .pulse_in   (pulse_in),
        .arm        (arm),
        .ack        (ack),
        .meas_delay (meas_delay),
        .meas_width (meas_width),
        .valid      (valid),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid && n < 200) begin
            tick(1);
            n++;
        end
        check({tag, "_valid"}, 32'(valid), 1);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    // Ref rises now; pulse rises 'dly' cycles later and stays high 'wid' cycles.
    task automatic run_meas(input int dly, input int wid);
        ref_clk = 1'b1;
        if (dly == 0) begin
            pulse_in = 1'b1;
        end else begin
            tick(dly);
            pulse_in = 1'b1;
        end
        tick(wid);
        pulse_in = 1'b0;
        ref_clk  = 1'b0;
    endtask

    task automatic check_result(input string tag, input int dly, input int wid, input int ovf);
        check({tag, "_delay"}, 32'(meas_delay), dly);
        check({tag, "_width"}, 32'(meas_width), wid);
        check({tag, "_ovf"},   32'(overflow),   ovf);
        check({tag, "_busy"},  32'(busy),       0);
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check({tag, "_ack_valid"}, 32'(valid), 0);
        check({tag, "_ack_busy"},  32'(busy),  0);
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy",  32'(busy),  0);
        check("rst_ovf",   32'(overflow), 0);
        check("rst_delay", 32'(meas_delay), 0);
        check("rst_width", 32'(meas_width), 0);
        reset = 1'b1;
        tick(2);

        // Basic: delay 3, width 2
        pulse_arm();
        check("s1_busy", 32'(busy), 1);
        check("s1_valid_early", 32'(valid), 0);
        run_meas(3, 2);
        wait_valid("s1");
        check_result("s1", 3, 2, 0);
        // Results hold through input activity while waiting for ack
        ref_clk = 1'b1;  tick(1);
        pulse_in = 1'b1; tick(1);
        pulse_in = 1'b0; ref_clk = 1'b0; tick(2);
        check("s1_hold_valid", 32'(valid), 1);
        check_result("s1_hold", 3, 2, 0);
        do_ack("s1");

        // Ref and pulse rise together, width 5
        pulse_arm();
        run_meas(0, 5);
        wait_valid("s2");
        check_result("s2", 0, 5, 0);
        do_ack("s2");

        // Pulse already high at arm/ref: only the later 0->1 counts
        pulse_in = 1'b1;
        tick(2);
        pulse_arm();
        ref_clk = 1'b1;
        tick(1);
        pulse_in = 1'b0;
        tick(3);
        pulse_in = 1'b1;
        tick(3);
        pulse_in = 1'b0;
        ref_clk  = 1'b0;
        wait_valid("s4");
        check_result("s4", 4, 3, 0);
        do_ack("s4");

        // Boundary: delay exactly at counter max, no overflow
        pulse_arm();
        run_meas(63, 1);
        wait_valid("s6");
        check_result("s6", 63, 1, 0);
        do_ack("s6");

        // Overflow: delay 70 saturates at 63, width still exact
        pulse_arm();
        run_meas(70, 4);
        wait_valid("s3");
        check_result("s3", 63, 4, 1);

        // ack+arm together in DONE restarts directly, overflow cleared
        ack = 1'b1;
        arm = 1'b1;
        tick(1);
        ack = 1'b0;
        arm = 1'b0;
        check("s5_valid", 32'(valid), 0);
        check("s5_busy",  32'(busy),  1);
        check("s5_ovf",   32'(overflow), 0);
        run_meas(2, 3);
        wait_valid("s5");
        check_result("s5", 2, 3, 0);
        do_ack("s5");

        // Reset in WAIT_FALL clears everything immediately
        pulse_arm();
        ref_clk = 1'b1;
        tick(2);
        pulse_in = 1'b1;
        tick(2);
        check("s7_busy_pre", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check("s7_valid", 32'(valid), 0);
        check("s7_busy",  32'(busy),  0);
        check("s7_ovf",   32'(overflow), 0);
        check("s7_delay", 32'(meas_delay), 0);
        check("s7_width", 32'(meas_width), 0);
        tick(2);
        reset = 1'b1;
        pulse_in = 1'b0;
        ref_clk  = 1'b0;
        tick(2);
        // Activity without arm must not start a measurement
        ref_clk = 1'b1;  tick(2);
        pulse_in = 1'b1; tick(3);
        pulse_in = 1'b0; ref_clk = 1'b0; tick(5);
        check("s7_noarm_valid", 32'(valid), 0);
        check("s7_noarm_busy",  32'(busy),  0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tcu_pulse_meter.md
TCU_PULSE_METER -- requirements
Module: tcu_pulse_meter

Interface
REQ-001 SHALL have parameter: CNT_W, default 6, width of all measurement counters and results.
REQ-002 SHALL have port: clk_in  input  1  measurement clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: ref_clk  input  1  start marker, asynchronous to clk_in; its rising edge starts a measurement.
REQ-005 SHALL have port: pulse_in  input  1  TCU output pulse under measurement, asynchronous to clk_in.
REQ-006 SHALL have port: arm  input  1  single-cycle request to start one measurement.
REQ-007 SHALL have port: ack  input  1  consumer acknowledge of the current result.
REQ-008 SHALL have port: meas_delay  output  CNT_W  clk_in cycles from ref_clk rise to pulse_in rise.
REQ-009 SHALL have port: meas_width  output  CNT_W  clk_in cycles pulse_in was high.
REQ-010 SHALL have port: valid  output  1  results stable and ready.
REQ-011 SHALL have port: overflow  output  1  a counter saturated during the reported measurement.
REQ-012 SHALL have port: busy  output  1  high in WAIT_REF, WAIT_RISE and WAIT_FALL.

Function
REQ-013 SHALL implement states IDLE, WAIT_REF, WAIT_RISE, WAIT_FALL, DONE.
REQ-014 SHALL detect edges on ref_s and pulse_s, the conditioned versions of ref_clk and pulse_in (REQ-028), by comparing each with its value one cycle earlier.
REQ-015 IDLE: arm=1 -> WAIT_REF, counter cleared, overflow cleared.
REQ-016 WAIT_REF: ref_s rise -> WAIT_RISE, counter=0; if pulse_s rises in the same cycle -> WAIT_FALL, meas_delay=0, counter=1.
REQ-017 WAIT_RISE: counter increments each cycle; on pulse_s rise, meas_delay <= counter value, counter=1, -> WAIT_FALL.
REQ-018 WAIT_FALL: counter increments each cycle while pulse_s high; on pulse_s fall, meas_width <= counter value, -> DONE.
REQ-019 pulse_in already high on entry to WAIT_RISE SHALL NOT count as a rise; only a 0->1 transition qualifies.
REQ-020 The counter SHALL saturate at 2^CNT_W-1 with no wrap-around, and SHALL set overflow, which stays set until the next arm is accepted.
REQ-021 DONE: valid=1, and results SHALL hold stable until ack.
REQ-022 DONE with ack=1 -> IDLE; DONE with ack=1 and arm=1 in the same cycle -> WAIT_REF, valid falls.
REQ-023 arm outside IDLE/DONE and ack outside DONE SHALL be ignored.
REQ-024 Further ref_clk edges in WAIT_RISE/WAIT_FALL SHALL be ignored.

Reset
REQ-025 reset low SHALL asynchronously force state=IDLE, meas_delay=0, meas_width=0, valid=0, overflow=0, busy=0, counter=0, and clear all edge and synchronizer flops to 0.
REQ-026 reset asserted mid-measurement SHALL discard the partial result; after reset release, no state transition occurs until arm is asserted.
REQ-027 Reset release SHALL NOT create a false edge: the edge-history flops load the current input only after the first post-reset cycle.

Configuration
REQ-028 With macro TCU_PULSE_METER_SYNC_EN defined, ref_clk and pulse_in SHALL each pass through a 2-flop synchronizer before edge detection, adding 2 cycles of equal latency to both paths so meas_delay and meas_width are unchanged.
REQ-029 Without TCU_PULSE_METER_SYNC_EN, ref_clk and pulse_in SHALL be used directly as ref_s and pulse_s, and a single history flop per input SHALL feed edge detection; this mode is for synchronous test benches only.

Verification
REQ-030 Bench SHALL cover: arm; ref rise; pulse rises 3 cycles later and stays high 2 cycles -> valid with meas_delay=3, meas_width=2, overflow=0.
REQ-031 Bench SHALL cover: ref and pulse rise in the same cycle, pulse high 5 cycles -> meas_delay=0, meas_width=5.
REQ-032 Bench SHALL cover: CNT_W=6, pulse rise 70 cycles after ref -> meas_delay=63, overflow=1, width still measured correctly.
REQ-033 Bench SHALL cover: pulse_in high at arm and ref rise, then falls, then rises 4 cycles after ref -> first high ignored, meas_delay=4.
REQ-034 Bench SHALL cover: reset pulled low in WAIT_FALL -> all outputs 0 immediately; after release, ref/pulse activity without arm -> valid stays 0.
REQ-035 Bench SHALL cover: ack and arm in the same DONE cycle -> valid drops next cycle, busy=1, and the next measurement completes correctly.
